// File: rtl/board_reset_halt_controller.sv
// board_reset_halt_controller
//
// Sequences the SoC reset and halt inputs from two raw push-buttons. Each button
// passes through a two-flop synchronizer and a counter debouncer. A power-on
// stretch holds the SoC in reset after controller reset. A minimum hold then
// applies to button-initiated resets. Halt is either toggled by each press or
// follows the debounced button level. Everything runs in the SoC clock domain.
//
// Ports:
//   clock         controller / SoC clock
//   reset         synchronous, active-high controller reset
//   reset_button  raw asynchronous reset push-button, active-high
//   halt_button   raw asynchronous halt push-button, active-high
//   soc_reset     registered SoC reset, active-high
//   soc_halt      registered SoC halt, active-high
//   reset_cause   cause of the last SoC reset: 2'b01 power-on, 2'b10 button
//
// Parameters:
//   DEBOUNCE_CYCLES    stable cycles needed before a debounced level flips (>= 1)
//   POR_CYCLES         soc_reset stretch after controller reset release (>= 1)
//   RESET_HOLD_CYCLES  minimum hold after a button-initiated reset (>= 1)
//   HALT_TOGGLE        1: each halt press toggles halt, 0: halt follows the button

module board_reset_halt_controller #(
  parameter int unsigned DEBOUNCE_CYCLES   = 500000,
  parameter int unsigned POR_CYCLES        = 1024,
  parameter int unsigned RESET_HOLD_CYCLES = 16,
  parameter bit          HALT_TOGGLE       = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       reset_button,
  input  logic       halt_button,
  output logic       soc_reset,
  output logic       soc_halt,
  output logic [1:0] reset_cause
);

  // One counter width covers every count, so no counter can wrap.
  localparam int unsigned MaxAB     = (DEBOUNCE_CYCLES > POR_CYCLES) ? DEBOUNCE_CYCLES
                                                                     : POR_CYCLES;
  localparam int unsigned MaxCycles = (MaxAB > RESET_HOLD_CYCLES) ? MaxAB
                                                                  : RESET_HOLD_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  localparam logic [CntW-1:0] DebLimit  = CntW'(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] PorLimit  = CntW'(POR_CYCLES);
  localparam logic [CntW-1:0] HoldLimit = CntW'(RESET_HOLD_CYCLES);
  localparam logic [CntW-1:0] CntOne    = CntW'(1);

  localparam logic [1:0] CausePor    = 2'b01;
  localparam logic [1:0] CauseButton = 2'b10;

  // Button index: 0 = reset button, 1 = halt button.
  localparam int unsigned BtnRst  = 0;
  localparam int unsigned BtnHalt = 1;

  typedef enum logic [1:0] {
    StPor  = 2'b00,
    StRun  = 2'b01,
    StHold = 2'b10
  } state_e;

  // Input path
  logic [1:0]           raw_btn;
  logic [1:0]           sync1_q, sync2_q;
  logic [1:0]           deb_q, deb_d;
  logic [1:0][CntW-1:0] deb_cnt_q, deb_cnt_d;

  // Sequencer
  state_e          state_q, state_d;
  logic [CntW-1:0] por_cnt_q, por_cnt_d;
  logic [CntW-1:0] hold_cnt_q, hold_cnt_d;
  logic [1:0]      cause_q, cause_d;

  // Halt and registered outputs
  logic halt_latch_q, halt_latch_d;
  logic soc_reset_q, soc_reset_d;
  logic soc_halt_q, soc_halt_d;
  logic run_stay;
  logic halt_rise;

  assign raw_btn = {halt_button, reset_button};

  // Debouncer: count cycles the synchronized input disagrees with the debounced
  // level. A flip is taken only on a disagreeing cycle seen with the count
  // already at the limit, so a pulse must be DEBOUNCE_CYCLES+1 samples long.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      deb_d[i]     = deb_q[i];
      deb_cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (deb_cnt_q[i] == DebLimit) begin
          deb_d[i] = ~deb_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + CntOne;
        end
      end
    end
  end

  // Sequencer next state. Reset decisions use the registered debounced level, so
  // soc_reset follows one cycle after the debounced reset button rises.
  always_comb begin
    state_d    = state_q;
    por_cnt_d  = por_cnt_q;
    hold_cnt_d = hold_cnt_q;
    cause_d    = cause_q;
    unique case (state_q)
      StPor: begin
        if (por_cnt_q == PorLimit) begin
          if (deb_q[BtnRst]) begin
            state_d    = StHold;
            hold_cnt_d = '0;
            cause_d    = CauseButton;
          end else begin
            state_d = StRun;
          end
        end else begin
          por_cnt_d = por_cnt_q + CntOne;
        end
      end
      StRun: begin
        if (deb_q[BtnRst]) begin
          state_d    = StHold;
          hold_cnt_d = '0;
          cause_d    = CauseButton;
        end
      end
      StHold: begin
        if (hold_cnt_q != HoldLimit) begin
          hold_cnt_d = hold_cnt_q + CntOne;
        end else if (!deb_q[BtnRst]) begin
          state_d = StRun;
        end
      end
      default: begin
        state_d = StPor;
      end
    endcase
  end

  // Halt. A debounced halt edge counts only when RUN is held across the edge.
  // A reset press debouncing on the same edge suppresses it (reset wins).
  always_comb begin
    run_stay     = (state_q == StRun) && (state_d == StRun);
    halt_rise    = deb_d[BtnHalt] & ~deb_q[BtnHalt];
    halt_latch_d = halt_latch_q;
    if (state_d != StRun) begin
      halt_latch_d = 1'b0;
    end else if (run_stay && halt_rise && !deb_d[BtnRst]) begin
      halt_latch_d = ~halt_latch_q;
    end

    if (HALT_TOGGLE) begin
      soc_halt_d = halt_latch_d;
    end else begin
      soc_halt_d = (state_d == StRun) && deb_d[BtnHalt] && !deb_d[BtnRst];
    end
    soc_reset_d = (state_d != StRun);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      deb_q        <= '0;
      deb_cnt_q    <= '0;
      state_q      <= StPor;
      por_cnt_q    <= '0;
      hold_cnt_q   <= '0;
      cause_q      <= CausePor;
      halt_latch_q <= 1'b0;
      soc_reset_q  <= 1'b1;
      soc_halt_q   <= 1'b0;
    end else begin
      sync1_q      <= raw_btn;
      sync2_q      <= sync1_q;
      deb_q        <= deb_d;
      deb_cnt_q    <= deb_cnt_d;
      state_q      <= state_d;
      por_cnt_q    <= por_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      cause_q      <= cause_d;
      halt_latch_q <= halt_latch_d;
      soc_reset_q  <= soc_reset_d;
      soc_halt_q   <= soc_halt_d;
    end
  end

  assign soc_reset   = soc_reset_q;
  assign soc_halt    = soc_halt_q;
  assign reset_cause = cause_q;

endmodule
